// File: rtl/matrix_add_vector_sequencer.sv
// Streams N column vectors through the shared 10-lane vector adder.
// Define MATADD_SEQ_PERF_CNT_EN to add the jobCycles busy-cycle counter.
module matrix_add_vector_sequencer #(
    parameter int MAX_VECTORS    = 10,
    parameter int ADDR_WIDTH     = 4,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vecCount,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rdEn,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic                  addInReady,
    input  logic                  addOutReady,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic                  vectorSetInNo,
    output logic                  vectorSetOutNo
`ifdef MATADD_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]           jobCycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seqState;

    localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH + 1)'(MAX_VECTORS);

    seqState                   state;
    logic                      rdEnQ;
    logic [MEM_RD_LATENCY-1:0] rdPipe;
    logic [ADDR_WIDTH:0]       nVec;
    logic [ADDR_WIDTH:0]       outIdx;
    logic [ADDR_WIDTH:0]       inFlight;
    logic [ADDR_WIDTH:0]       nClamp;
    logic                      active;
    logic                      orphan;
    logic                      accept;
    logic                      lastIssue;
    logic                      lastOut;

    always_comb begin
        nClamp     = (vecCount > MAX_N) ? MAX_N : vecCount;
        active     = (state == ISSUE) || (state == DRAIN);
        // A result strobe with nothing outstanding is a protocol error
        orphan     = addOutReady && (inFlight == '0) && !addInReady;
        accept     = (state == IDLE) && start && enable;
        wrEn       = addOutReady && enable && active && !orphan;
        rdEn       = rdEnQ && enable;
        done       = (state == DONE) && enable;
        busy       = (state != IDLE);
        addInReady = rdPipe[MEM_RD_LATENCY-1];
        wrAddr     = outIdx[ADDR_WIDTH-1:0];
        lastIssue  = ({1'b0, rdAddr} == (nVec - 1'b1));
        lastOut    = wrEn && ((outIdx + 1'b1) == nVec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rdEnQ          <= 1'b0;
            rdAddr         <= '0;
            rdPipe         <= '0;
            nVec           <= '0;
            outIdx         <= '0;
            inFlight       <= '0;
            err            <= 1'b0;
            vectorSetInNo  <= 1'b0;
            vectorSetOutNo <= 1'b1;
        end else if (enable) begin
            rdPipe <= MEM_RD_LATENCY'({rdPipe, rdEnQ});

            case ({addInReady, addOutReady && !orphan})
                2'b10:   inFlight <= inFlight + 1'b1;
                2'b01:   inFlight <= inFlight - 1'b1;
                default: inFlight <= inFlight;
            endcase

            if (accept) begin
                err <= 1'b0;
            end else if (orphan) begin
                err <= 1'b1;
            end

            if (accept) begin
                outIdx <= '0;
            end else if (wrEn) begin
                outIdx <= outIdx + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        nVec          <= nClamp;
                        rdAddr        <= '0;
                        vectorSetInNo <= ~vectorSetInNo;
                        if (nClamp == '0) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                            rdEnQ <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (lastIssue) begin
                        rdEnQ <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rdAddr <= rdAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lastOut) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    vectorSetOutNo <= ~vectorSetOutNo;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATADD_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jobCycles <= '0;
        end else if (enable) begin
            if (accept) begin
                jobCycles <= '0;
            end else if (busy && (jobCycles != 16'hFFFF)) begin
                jobCycles <= jobCycles + 16'd1;
            end
        end
    end
`endif

endmodule
